// File: rtl/dc_fifo_pkg.sv
// Shared definitions for the dual-clock slice FIFO controllers.
// DC_DIN_SYNC3_EN selects 3-flop token synchronizers instead of 2.
package dc_fifo_pkg;

`ifdef DC_DIN_SYNC3_EN
    localparam int DC_SYNC_STAGES = 3;
`else
    localparam int DC_SYNC_STAGES = 2;
`endif

    localparam int DC_TOK_MAX = 1024;
    localparam logic [DC_TOK_MAX-1:0] DC_TOK_RST = DC_TOK_MAX'(1);

    // Rotate the low w bits of v left by one; bits at and above w come back zero.
    function automatic logic [DC_TOK_MAX-1:0] rotl1(input logic [DC_TOK_MAX-1:0] v,
                                                    input int w);
        logic [DC_TOK_MAX-1:0] r;
        r = '0;
        r[0] = v[w-1];
        for (int i = 1; i < DC_TOK_MAX; i++) begin
            if (i < w) r[i] = v[i-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/dc_token_synchronizer.sv
// Per-bit multi-flop synchronizer for a one-hot token crossing clock domains.
// Every stage resets to the token reset value so both sides start aligned.
module dc_token_synchronizer
    import dc_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = DC_SYNC_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int s = 0; s < STAGES; s++) r_stage[s] <= DC_TOK_RST[WIDTH-1:0];
        end else begin
            r_stage[0] <= i_async;
            for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/dc_fifo_din_ctrl.sv
// Write-side controller of the dual-clock slice FIFO: one-hot write token plus
// not-full flag. DC_DIN_SYNC3_EN lengthens the read-token synchronizer to 3 flops.
module dc_fifo_din_ctrl
    import dc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    ready,
    output logic [BUFFER_DEPTH-1:0] write_pointer,
    output logic [DATA_WIDTH-1:0]   write_data,
    input  logic [BUFFER_DEPTH-1:0] read_pointer
);

    logic [BUFFER_DEPTH-1:0] r_tok;
    logic                    r_init;
    logic [BUFFER_DEPTH-1:0] w_rd_sync;
    logic [DC_TOK_MAX-1:0]   w_rot_full;
    logic                    w_full;
    logic                    w_accept;

    dc_token_synchronizer #(
        .WIDTH  (BUFFER_DEPTH),
        .STAGES (DC_SYNC_STAGES)
    ) u_rd_sync (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_async (read_pointer),
        .o_sync  (w_rd_sync)
    );

    // Two bits set in the synchronized token only ever yields a pessimistic full.
    assign w_rot_full = rotl1(DC_TOK_MAX'(r_tok), BUFFER_DEPTH);
    assign w_full     = |(w_rot_full & DC_TOK_MAX'(w_rd_sync));
    assign ready      = r_init & ~w_full;
    assign w_accept   = valid & ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tok  <= DC_TOK_RST[BUFFER_DEPTH-1:0];
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (w_accept) r_tok <= w_rot_full[BUFFER_DEPTH-1:0];
        end
    end

    assign write_pointer = r_tok;
    assign write_data    = data;

endmodule

// File: tb/tb_dc_fifo_din_ctrl.sv
// Bench for dc_fifo_din_ctrl: directed test-plan sequences plus a randomized
// writer/reader run, checked against a slot-index model and a word scoreboard.
module tb_dc_fifo_din_ctrl;
    import dc_fifo_pkg::*;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int NS = DC_SYNC_STAGES;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic [N-1:0]  read_pointer = N'(1);
    logic          ready;
    logic [N-1:0]  write_pointer;
    logic [DW-1:0] write_data;

    dc_fifo_din_ctrl #(
        .DATA_WIDTH   (DW),
        .BUFFER_DEPTH (N)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .valid         (valid),
        .data          (data),
        .ready         (ready),
        .write_pointer (write_pointer),
        .write_data    (write_data),
        .read_pointer  (read_pointer)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: write slot index, read-token samples seen at past edges, accepted words.
    int            m_wr = 0;
    bit            m_init = 1'b0;
    logic [N-1:0]  m_seen [NS];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] buf_mem [N];

    function automatic bit m_ready();
        logic [N-1:0] oldest;
        oldest = m_seen[NS-1];
        return m_init && (oldest[(m_wr + 1) % N] !== 1'b1);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_wr   = 0;
            m_init = 1'b0;
            for (int s = 0; s < NS; s++) m_seen[s] = N'(1);
            sb.delete();
        end else begin
            bit acc;
            acc = valid && m_ready();
            for (int j = 0; j < N; j++) if (write_pointer[j]) buf_mem[j] = write_data;
            if (acc) begin
                sb.push_back(data);
                m_wr = (m_wr + 1) % N;
            end
            for (int s = NS - 1; s > 0; s--) m_seen[s] = m_seen[s-1];
            m_seen[0] = read_pointer;
            m_init = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("ready", ready, m_ready());
        check("write_pointer", write_pointer, N'(1) << m_wr);
        check("write_data", write_data, data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid        = 1'b0;
        data         = '0;
        read_pointer = N'(1);
        rstn         = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_wp", write_pointer, 8'h01);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check("rel_ready_pre", ready, 0);
        check("rel_wp_pre", write_pointer, 8'h01);
        step();
        check("rel_ready_post", ready, 1);
        check("rel_wp_post", write_pointer, 8'h01);
    endtask

    task automatic fill7(input bit rand_data);
        for (int i = 0; i < 7; i++) begin
            data  = rand_data ? DW'($urandom) : DW'(i);
            valid = 1'b1;
            step();
            check("fill_wp", write_pointer, N'(1) << (i + 1));
        end
    endtask

    initial begin
        int rd_idx;
        int rate;
        bit acc;

        #2;
        do_reset();

        // Fill to capacity with 0..6.
        fill7(1'b0);
        valid = 1'b0;
        check("full_wp", write_pointer, 8'h80);
        check("full_ready", ready, 0);
        for (int i = 0; i < 7; i++) check("buf_contents", buf_mem[i], DW'(i));

        // Reader moves to slot 1: release after NS edges, then wrap.
        read_pointer = 8'h02;
        for (int k = 0; k < NS - 1; k++) begin
            step();
            check("release_early", ready, 0);
        end
        step();
        check("release", ready, 1);
        valid = 1'b1;
        data  = 32'd7;
        step();
        valid = 1'b0;
        check("wrap_wp", write_pointer, 8'h01);
        check("wrap_full", ready, 0);
        check("wrap_buf", buf_mem[7], 32'd7);

        // Skewed read-token samples.
        read_pointer = 8'h00;
        repeat (NS) step();
        check("skew_zero_ready", ready, 1);
        read_pointer = 8'h03;
        repeat (NS) step();
        check("skew_two_ready", ready, 0);
        check("skew_two_wp", write_pointer, 8'h01);
        read_pointer = 8'h00;
        repeat (NS) step();
        check("skew_zero_again", ready, 1);

        // Held word under back-pressure is accepted exactly once.
        do_reset();
        fill7(1'b1);
        valid = 1'b1;
        data  = 32'hA5A5_0001;
        repeat (5) begin
            step();
            check("hold_wp", write_pointer, 8'h80);
            check("hold_ready", ready, 0);
        end
        read_pointer = 8'h02;
        repeat (NS) step();
        check("hold_release", ready, 1);
        step();
        valid = 1'b0;
        check("hold_accept_wp", write_pointer, 8'h01);
        check("hold_accept_ready", ready, 0);
        check("hold_accept_buf", buf_mem[7], 32'hA5A5_0001);
        step();
        check("hold_once_wp", write_pointer, 8'h01);

        // Asynchronous reset mid-burst.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            data  = DW'($urandom);
            step();
        end
        check("burst_wp", write_pointer, 8'h10);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_wp", write_pointer, 8'h01);
        check("async_rst_ready", ready, 0);
        do_reset();

        // Random writer against a modelled reader.
        rd_idx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rate = (cyc / 500) % 3;
            if (rd_idx != m_wr) begin
                if ((rate == 0 && $urandom_range(0, 7) == 0) ||
                    (rate == 1 && $urandom_range(0, 7) != 0) ||
                    (rate == 2 && $urandom_range(0, 1) == 0)) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 0, 1);
                    end else begin
                        check("pop_data", buf_mem[rd_idx], sb.pop_front());
                    end
                    rd_idx = (rd_idx + 1) % N;
                    read_pointer = N'(1) << rd_idx;
                end
            end
            #1;
            acc = valid && ready;
            step();
            if (!(valid && !acc)) begin
                valid = ($urandom_range(0, 3) != 0);
                data  = DW'($urandom);
            end
        end
        valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_fifo_din_ctrl.md
# dc_fifo_din_ctrl

Write-side controller of the dual-clock AXI slice FIFO. Sits directly upstream of the slice data buffer.
- Accepts words over a valid/ready handshake in the write clock domain.
- Passes each word straight to the buffer's `write_data`.
- Drives the buffer's one-hot `write_pointer` as a rotating token.
- Produces `ready` (not-full) by comparing the token with a locally synchronized copy of the read domain's one-hot read pointer.

## Interface
- `DATA_WIDTH`, 32, word width; must equal the buffer's `DATA_WIDTH`.
- `BUFFER_DEPTH`, 8, number of buffer slots and one-hot token width; legal range 3..1024. Usable capacity is `BUFFER_DEPTH-1`.
- `clk` input 1: write-domain clock. Every flop in the block is clocked on its rising edge.
- `rstn` input 1: reset, asynchronous, active-low, applied to every flop.
- `valid` input 1: upstream word valid.
- `data` input DATA_WIDTH: upstream word.
- `ready` output 1: block can accept a word this cycle.
- `write_pointer` output BUFFER_DEPTH: one-hot slot the buffer writes every `clk` edge.
- `write_data` output DATA_WIDTH: equals `data`, combinational pass-through.
- `read_pointer` input BUFFER_DEPTH: one-hot read token from the read domain; asynchronous to `clk`.

## Operation
- Token register `wr_tok` drives `write_pointer`.
  - Reset value: `1` (bit 0).
  - On `valid && ready`, it rotates left by one: bit N-1 wraps to bit 0.
  - Otherwise it holds.
- The buffer overwrites slot `write_pointer` every edge. The value in that slot at the accepting edge is therefore the committed word. Upstream must keep `data` stable while `valid && !ready` (AXI rule).
- Synchronizer:
  - Each bit of `read_pointer` passes through an independent 2-flop chain.
  - The last stage is `rd_sync`; every stage resets to `1` (bit 0), matching the read side's reset token.
- Full detection: `full = |(rotl(wr_tok,1) & rd_sync)`.
  - Full means the next write slot is the slot the reader will read next.
  - Empty is `wr_tok == read_pointer` and is owned by the read side.
- Skew tolerance:
  - A token move sampled mid-transition can appear in `rd_sync` as two bits set or zero bits set.
  - Two bits set gives a pessimistic full, which is safe.
  - Zero bits set only occurs once the reader has left its slot, so reporting not-full is correct.
- `init_q`: one flop, reset 0, set to 1 on the first edge after `rstn` rises.
- `ready = init_q & ~full`.
- Simultaneous accept and `rd_sync` change on the same edge: `ready` for the next cycle uses the updated `wr_tok` and `rd_sync` together.
- Reset mid-operation: all state returns to its reset value immediately. Any word in flight is dropped. The read side must also be reset.

## Timing
- Reset outputs:
  - `ready=0`
  - `write_pointer=1`
  - `write_data=data`
- `ready` rises on the first edge after reset release.
- Accept latency: `write_pointer` advances on the accepting edge. The word is stored at that same edge.
- Throughput: one word per cycle while not full.
- Back-pressure release: a `read_pointer` change is visible in `rd_sync` after 2 `clk` edges. `ready` rises right after the second edge (after the third edge when `DC_DIN_SYNC3_EN` is defined).
- Full assertion: `ready` drops combinationally on the edge that makes `rotl(wr_tok,1)` hit `rd_sync`. No overrun is possible.

## Configuration
- Macro `DC_DIN_SYNC3_EN`:
  - Defined: each synchronizer chain is 3 flops, and release latency is 3 edges.
  - Undefined: each chain is 2 flops.
  - Reset value and full logic are the same in both cases.

## Structure
- Shared package `dc_fifo_pkg` holds:
  - `DC_SYNC_STAGES`, 2 or 3, selected by the macro;
  - the `rotl1` function on a one-hot vector;
  - the token reset constant (bit 0 set).
- The read-side controller imports the same package.
- Sub-module `dc_token_synchronizer`:
  - parameters: width and stage count;
  - reset: async active-low, reset value one-hot bit 0;
  - reused by the read-side controller.

## Test plan
- Reset, then release with `valid=0`: `ready=0` during reset, `ready=1` after the first edge; `write_pointer=8'h01` throughout.
- `read_pointer=8'h01` static, `valid=1` continuously with data 0..6:
  - 7 accepts;
  - `write_pointer` steps 01→02→…→80;
  - `ready=0` after the 7th accept;
  - buffer holds 0..6.
- From that full state, set `read_pointer=8'h02`: `ready=1` after exactly 2 edges (3 edges with `DC_DIN_SYNC3_EN`). The next accept wraps `write_pointer` to `8'h01`.
- Drive `read_pointer=8'h03` (transient) while `write_pointer=8'h01`: `ready=0` (pessimistic full). `read_pointer=8'h00`: `ready=1`.
- Assert `rstn=0` for one cycle mid-burst, with `write_pointer=8'h10`: `write_pointer=8'h01` and `ready=0` immediately, asynchronously.
- Hold `valid=1`, `ready=0` for 5 cycles with data `A5A5_0001`: `write_pointer` unchanged, and the word is accepted exactly once when `ready` rises.
